// File: rtl/traffic_phase_timer.sv
// rtl/traffic_phase_timer.sv - tick-driven GREEN/YELLOW/RED phase sequencer with pedestrian red extension
module traffic_phase_timer #(
  parameter int CNT_W        = 8,
  parameter int GREEN_TICKS  = 20,
  parameter int YELLOW_TICKS = 4,
  parameter int RED_TICKS    = 16,
  parameter int PED_EXTEND   = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             tick,
  input  logic             hold,
  input  logic             ped_req,
  output logic             advance,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] remaining,
  output logic             ped_pending,
  output logic             ped_walk
);

  if (GREEN_TICKS < 1 || YELLOW_TICKS < 1 || RED_TICKS < 1 || PED_EXTEND < 1) begin : g_bad_ticks
    $error("traffic_phase_timer: every tick parameter must be at least 1");
  end
  if (longint'(RED_TICKS) + longint'(PED_EXTEND) > (longint'(1) << CNT_W)) begin : g_bad_width
    $error("traffic_phase_timer: extended red length does not fit in CNT_W");
  end

  typedef enum logic [1:0] {
    ST_INIT   = 2'b00,
    ST_GREEN  = 2'b01,
    ST_YELLOW = 2'b10,
    ST_RED    = 2'b11
  } phase_t;

  localparam logic [CNT_W-1:0] GREEN_LOAD   = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] YELLOW_LOAD  = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] RED_LOAD     = CNT_W'(RED_TICKS - 1);
  localparam logic [CNT_W-1:0] RED_EXT_LOAD = CNT_W'(RED_TICKS + PED_EXTEND - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  phase_t           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             adv_q, adv_d;
  logic             pend_q, pend_d;
  logic             walk_q, walk_d;
  logic             qual;
  logic             expire;
  logic             enter_red;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_INIT;
      rem_q   <= '0;
      adv_q   <= 1'b0;
      pend_q  <= 1'b0;
      walk_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      adv_q   <= adv_d;
      pend_q  <= pend_d;
      walk_q  <= walk_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    adv_d     = 1'b0;
    walk_d    = walk_q;
    qual      = tick & enable & ~hold;
    expire    = qual & ((state_q == ST_INIT) | (rem_q == '0));
    enter_red = expire & (state_q == ST_YELLOW);

    if (expire) begin
      adv_d = 1'b1;
      unique case (state_q)
        ST_INIT, ST_RED: begin
          state_d = ST_GREEN;
          rem_d   = GREEN_LOAD;
          walk_d  = 1'b0;
        end
        ST_GREEN: begin
          state_d = ST_YELLOW;
          rem_d   = YELLOW_LOAD;
        end
        ST_YELLOW: begin
          state_d = ST_RED;
          // a press arriving on the very cycle red is chosen still earns the extension
          if (pend_q | ped_req) begin
            rem_d  = RED_EXT_LOAD;
            walk_d = 1'b1;
          end else begin
            rem_d  = RED_LOAD;
            walk_d = 1'b0;
          end
        end
      endcase
    end else if (qual) begin
      rem_d = rem_q - CNT_ONE;
    end

    pend_d = enter_red ? 1'b0 : (pend_q | ped_req);
  end

  assign advance     = adv_q;
  assign phase       = state_q;
  assign remaining   = rem_q;
  assign ped_pending = pend_q;
  assign ped_walk    = walk_q;

endmodule

// File: tb/tb_traffic_phase_timer.sv
// tb/tb_traffic_phase_timer.sv - self-checking bench for traffic_phase_timer
module tb_traffic_phase_timer;

  localparam int CNT_W = 4;
  localparam int G = 3;
  localparam int Y = 2;
  localparam int R = 4;
  localparam int P = 2;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             enable = 1'b0;
  logic             tick = 1'b0;
  logic             hold = 1'b0;
  logic             ped_req = 1'b0;
  logic             advance;
  logic [1:0]       phase;
  logic [CNT_W-1:0] remaining;
  logic             ped_pending;
  logic             ped_walk;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  traffic_phase_timer #(
    .CNT_W(CNT_W), .GREEN_TICKS(G), .YELLOW_TICKS(Y), .RED_TICKS(R), .PED_EXTEND(P)
  ) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .tick(tick), .hold(hold),
    .ped_req(ped_req), .advance(advance), .phase(phase), .remaining(remaining),
    .ped_pending(ped_pending), .ped_walk(ped_walk)
  );

  always #5 clock = ~clock;

  // Reference: phase number 0..3, ticks left minus one, and the pedestrian flags.
  int m_phase, m_rem;
  bit m_adv, m_pend, m_walk;

  function automatic int phase_len(input int ph);
    case (ph)
      1: return G;
      2: return Y;
      default: return R;
    endcase
  endfunction

  always @(posedge clock or negedge reset_n) begin
    int  nph, nrem;
    bit  nwalk, nadv, to_red;
    if (!reset_n) begin
      m_phase <= 0; m_rem <= 0; m_adv <= 0; m_pend <= 0; m_walk <= 0;
    end else begin
      nph = m_phase; nrem = m_rem; nwalk = m_walk; nadv = 0; to_red = 0;
      if (tick && enable && !hold) begin
        if (m_phase == 0 || m_rem == 0) begin
          nph  = (m_phase == 3) ? 1 : m_phase + 1;
          nrem = phase_len(nph) - 1;
          nadv = 1;
          nwalk = 0;
          if (nph == 3) begin
            to_red = 1;
            if (m_pend || ped_req) begin
              nrem  = nrem + P;
              nwalk = 1;
            end
          end
        end else begin
          nrem = m_rem - 1;
        end
      end
      m_phase <= nph;
      m_rem   <= nrem;
      m_adv   <= nadv;
      m_walk  <= nwalk;
      m_pend  <= to_red ? 1'b0 : (m_pend | ped_req);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (chk_on) begin
      chk("cyc.phase", 32'(phase), 32'(m_phase));
      chk("cyc.remaining", 32'(remaining), 32'(m_rem));
      chk("cyc.advance", 32'(advance), 32'(m_adv));
      chk("cyc.ped_pending", 32'(ped_pending), 32'(m_pend));
      chk("cyc.ped_walk", 32'(ped_walk), 32'(m_walk));
    end
  end

  task automatic expect_st(input string name, input int ph, input int rem,
                           input int adv, input int pend, input int walk);
    chk({name, ".phase"}, 32'(phase), 32'(ph));
    chk({name, ".remaining"}, 32'(remaining), 32'(rem));
    chk({name, ".advance"}, 32'(advance), 32'(adv));
    chk({name, ".ped_pending"}, 32'(ped_pending), 32'(pend));
    chk({name, ".ped_walk"}, 32'(ped_walk), 32'(walk));
  endtask

  task automatic step(input logic t, input logic h, input logic e, input logic p);
    tick = t; hold = h; enable = e; ped_req = p;
    @(negedge clock);
  endtask

  task automatic tk(input logic p);
    repeat (3) step(0, 0, 1, 0);
    step(1, 0, 1, p);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    chk_on = 1'b1;
    expect_st("reset", 0, 0, 0, 0, 0);
    reset_n = 1'b1;

    // basic cycle, one tick every 4 clocks
    tk(0); expect_st("tick1", 1, 2, 1, 0, 0);
    step(0, 0, 1, 0); expect_st("tick1_after", 1, 2, 0, 0, 0);
    tk(0); tk(0); expect_st("tick3", 1, 0, 0, 0, 0);
    tk(0); expect_st("tick4", 2, 1, 1, 0, 0);
    tk(0); tk(0); expect_st("tick6", 3, 3, 1, 0, 0);
    repeat (3) tk(0); expect_st("tick9", 3, 0, 0, 0, 0);
    tk(0); expect_st("tick10", 1, 2, 1, 0, 0);

    // pedestrian press in green gives an extended red
    step(0, 0, 1, 1); expect_st("ped_green", 1, 2, 0, 1, 0);
    repeat (5) tk(0); expect_st("ext_red", 3, 5, 1, 0, 1);
    repeat (5) tk(0); expect_st("ext_red_end", 3, 0, 0, 0, 1);
    tk(0); expect_st("after_ext", 1, 2, 1, 0, 0);
    repeat (5) tk(0); expect_st("normal_red", 3, 3, 1, 0, 0);

    // press on the yellow->red tick itself
    repeat (8) tk(0); expect_st("yellow_last", 2, 0, 0, 0, 0);
    tk(1); expect_st("same_cycle_ped", 3, 5, 1, 0, 1);

    // press during extended red carries to the next red
    step(0, 0, 1, 1); expect_st("ped_in_ext", 3, 5, 0, 1, 1);
    repeat (6) tk(0); expect_st("green_pending", 1, 2, 1, 1, 0);
    repeat (5) tk(0); expect_st("second_ext", 3, 5, 1, 0, 1);

    // hold in yellow
    repeat (9) tk(0); expect_st("yellow_entry", 2, 1, 1, 0, 0);
    repeat (10) step(1, 1, 1, 0); expect_st("held", 2, 1, 0, 0, 0);
    tk(0); tk(0); expect_st("hold_release", 3, 3, 1, 0, 0);

    // enable low freezes timing but still latches presses
    repeat (5) step(1, 0, 0, 0); expect_st("disabled", 3, 3, 0, 0, 0);
    step(0, 0, 0, 1); expect_st("ped_disabled", 3, 3, 0, 1, 0);

    // asynchronous reset mid-red
    #2 reset_n = 1'b0;
    #1 expect_st("async_reset", 0, 0, 0, 0, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    step(0, 0, 1, 0); step(0, 0, 1, 0); expect_st("post_reset_idle", 0, 0, 0, 0, 0);
    step(1, 0, 1, 0); expect_st("post_reset_tick", 1, 2, 1, 0, 0);

    // back-to-back ticks
    step(1, 0, 1, 0); expect_st("b2b_1", 1, 1, 0, 0, 0);
    step(1, 0, 1, 0); step(1, 0, 1, 0); expect_st("b2b_3", 2, 1, 1, 0, 0);
    step(1, 0, 1, 0); expect_st("b2b_4", 2, 0, 0, 0, 0);
    step(0, 0, 1, 0);

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/traffic_phase_timer.md
TRAFFIC_PHASE_TIMER -- requirements
Module: traffic_phase_timer

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the phase countdown.
REQ-002 SHALL have parameter GREEN_TICKS, default 20: green phase length in ticks.
REQ-003 SHALL have parameter YELLOW_TICKS, default 4: yellow phase length in ticks.
REQ-004 SHALL have parameter RED_TICKS, default 16: red phase length in ticks.
REQ-005 SHALL have parameter PED_EXTEND, default 8: extra red ticks when a pedestrian request is served.
REQ-006 SHALL have port clock, input, 1: single clock; all state changes on its rising edge.
REQ-007 SHALL have port reset_n, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port enable, input, 1: run gate; low freezes all timing.
REQ-009 SHALL have port tick, input, 1: one-cycle timebase strobe (e.g. 1 Hz prescaler).
REQ-010 SHALL have port hold, input, 1: freezes the countdown in the current phase.
REQ-011 SHALL have port ped_req, input, 1: pedestrian button, level or pulse.
REQ-012 SHALL have port advance, output, 1: one-cycle strobe that steps the downstream light controller.
REQ-013 SHALL have port phase, output, 2: current phase; 00 INIT, 01 GREEN, 10 YELLOW, 11 RED.
REQ-014 SHALL have port remaining, output, CNT_W: ticks left in the current phase minus one.
REQ-015 SHALL have port ped_pending, output, 1: a pedestrian request is latched and not yet served.
REQ-016 SHALL have port ped_walk, output, 1: the walk indication, high for the whole of an extended red phase.

Function
REQ-017 SHALL count only on a cycle where tick=1, enable=1 and hold=0 (a qualifying tick).
REQ-018 SHALL run the state machine INIT->GREEN->YELLOW->RED->GREEN; INIT is never re-entered except by reset.
REQ-019 SHALL leave INIT on the first qualifying tick: next cycle phase=GREEN, remaining=GREEN_TICKS-1, advance=1.
REQ-020 SHALL, on a qualifying tick with remaining>0, decrement remaining by 1 with no advance.
REQ-021 SHALL, on a qualifying tick with remaining==0, in the next cycle move phase to the successor, load remaining with the successor length minus 1, and pulse advance for exactly one cycle.
REQ-022 SHALL, on entering RED with ped_pending=1 (including a ped_req in that same cycle), load RED_TICKS+PED_EXTEND-1, set ped_walk=1, and clear ped_pending.
REQ-023 SHALL otherwise enter RED with RED_TICKS-1 and ped_walk=0.
REQ-024 SHALL set ped_walk=0 when leaving RED.
REQ-025 SHALL set ped_pending on any cycle with ped_req=1 and not entering RED, regardless of enable/hold.
REQ-026 SHALL treat ped_req during an extended red as a new request for the next red.
REQ-027 SHALL ignore tick when enable=0 or hold=1: phase, remaining and advance are frozen (advance=0).
REQ-028 SHALL produce an advance pulse no more than one cycle long; back-to-back ticks still yield one cycle per phase change.
REQ-029 SHALL require all tick parameters >=1 and RED_TICKS+PED_EXTEND <= 2^CNT_W; a violation is a compile-time error.
REQ-030 SHALL keep remaining free of wrap: it never decrements below 0.

Reset
REQ-031 SHALL, while reset_n=0, asynchronously force phase=00, remaining=0, advance=0, ped_pending=0, ped_walk=0.
REQ-032 SHALL, on reset mid-phase, discard all timing and latched requests; the first qualifying tick after release behaves per REQ-019.
REQ-033 SHALL deassert reset synchronously at the block boundary, and the first rising edge after release SHALL be a normal cycle.

Verification (GREEN=3, YELLOW=2, RED=4, PED=2, CNT_W=4)
REQ-034 Reset then ticks every 4 cycles -> advance at tick 1 (GREEN,rem 2), tick 4 (YELLOW,rem 1), tick 6 (RED,rem 3), tick 10 (GREEN); one-cycle advance each time.
REQ-035 ped_req pulse during GREEN -> ped_pending=1; RED entered with rem=5 and ped_walk=1 for 6 ticks; ped_pending=0; next RED normal (rem=3).
REQ-036 ped_req in the same cycle as YELLOW->RED advance -> extended red (rem=5), ped_pending never left set.
REQ-037 hold=1 for 10 ticks in YELLOW with rem=1 -> no change; release -> two more ticks to RED.
REQ-038 enable=0 with ticks, then assert reset_n=0 mid-RED -> outputs zero immediately; after release, first tick -> GREEN, rem=2.
